// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and screen/color constants for the stacking game
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_FALL = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int COLOR_W = 2;
  localparam logic [COLOR_W-1:0] COLOR_EMPTY = 2'd0;

  // A spawned block is never empty-colored; fold 0 onto color 1.
  function automatic logic [COLOR_W-1:0] spawn_color(input logic [COLOR_W-1:0] raw);
    return (raw == COLOR_EMPTY) ? 2'd1 : raw;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR, taps 16/14/13/11, advances when en is high
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

endmodule

// File: rtl/drop_scheduler.sv
// rtl/drop_scheduler.sv - game FSM that spawns, drops and retires falling blocks for the stack datapath
module drop_scheduler
  import game_pkg::*;
#(
  parameter logic [19:0] FALL_DIV   = 20'd200000,
  parameter logic [23:0] SPAWN_GAP  = 24'd5000000,
  parameter logic [9:0]  FLOOR_Y    = 10'd470,
  parameter logic [9:0]  X_MIN      = 10'd20,
  parameter logic [4:0]  MAX_HEIGHT = 5'd16,
  parameter logic [1:0]  MAX_MISSES = 2'd3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               collision,
  output logic [9:0]         fall_x,
  output logic [9:0]         fall_y,
  output logic [COLOR_W-1:0] fall_color,
  output logic               fall_valid,
  output logic [4:0]         score,
  output logic [1:0]         misses,
  output logic               game_over,
  output logic               win
);

  state_t state_q, state_d;

  logic [23:0]        gap_cnt_q, gap_cnt_d;
  logic [19:0]        div_cnt_q, div_cnt_d;
  logic [9:0]         fall_x_q, fall_x_d;
  logic [9:0]         fall_y_q, fall_y_d;
  logic [COLOR_W-1:0] fall_color_q, fall_color_d;
  logic               fall_valid_q, fall_valid_d;
  logic [4:0]         score_q, score_d;
  logic [1:0]         misses_q, misses_d;
  logic               win_q, win_d;

  logic [15:0] lfsr_q;
  logic        lfsr_en;
  logic        lfsr_unused;

  assign lfsr_en     = ~pause;
  assign lfsr_unused = ^lfsr_q[15:11];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .q   (lfsr_q)
  );

  logic       in_fall, at_floor, go, spawn, hit, miss, step, retire;
  logic [4:0] score_inc;
  logic [1:0] misses_inc;

  // Collision wins over everything in FALL, even while paused.
  assign in_fall    = (state_q == ST_FALL);
  assign at_floor   = (fall_y_q >= FLOOR_Y);
  assign go         = start & ~pause & ((state_q == ST_IDLE) | (state_q == ST_OVER));
  assign spawn      = (state_q == ST_GAP) & ~pause & (gap_cnt_q == SPAWN_GAP - 24'd1);
  assign hit        = in_fall & collision;
  assign miss       = in_fall & ~collision & ~pause & at_floor;
  assign step       = in_fall & ~collision & ~pause & ~at_floor & (div_cnt_q == FALL_DIV - 20'd1);
  assign retire     = hit | miss;
  assign score_inc  = (score_q < MAX_HEIGHT) ? score_q + 5'd1 : score_q;
  assign misses_inc = (misses_q < MAX_MISSES) ? misses_q + 2'd1 : misses_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (go) state_d = ST_GAP;
      ST_GAP:           if (spawn) state_d = ST_FALL;
      ST_FALL: begin
        if (hit) begin
          state_d = (score_inc == MAX_HEIGHT) ? ST_OVER : ST_GAP;
        end else if (miss) begin
          state_d = (misses_inc == MAX_MISSES) ? ST_OVER : ST_GAP;
        end
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    game_over = (state_q == ST_OVER);
  end

  always_comb begin
    gap_cnt_d    = gap_cnt_q;
    div_cnt_d    = div_cnt_q;
    fall_x_d     = fall_x_q;
    fall_y_d     = fall_y_q;
    fall_color_d = fall_color_q;
    fall_valid_d = fall_valid_q;
    score_d      = score_q;
    misses_d     = misses_q;
    win_d        = win_q;

    if (go || retire) begin
      gap_cnt_d = 24'd0;
    end else if (state_q == ST_GAP && !pause) begin
      gap_cnt_d = gap_cnt_q + 24'd1;
    end

    if (spawn) begin
      div_cnt_d = 20'd0;
    end else if (in_fall && !pause) begin
      div_cnt_d = (div_cnt_q == FALL_DIV - 20'd1) ? 20'd0 : div_cnt_q + 20'd1;
    end

    if (spawn) begin
      fall_x_d     = X_MIN + {1'b0, lfsr_q[8:0]};
      fall_y_d     = 10'd0;
      fall_color_d = spawn_color(lfsr_q[10:9]);
      fall_valid_d = 1'b1;
    end else if (retire) begin
      fall_y_d     = 10'd0;
      fall_color_d = COLOR_EMPTY;
      fall_valid_d = 1'b0;
    end else if (step) begin
      fall_y_d = fall_y_q + 10'd1;
    end

    if (go) begin
      score_d  = 5'd0;
      misses_d = 2'd0;
      win_d    = 1'b0;
    end else if (hit) begin
      score_d = score_inc;
      if (score_inc == MAX_HEIGHT) win_d = 1'b1;
    end else if (miss) begin
      misses_d = misses_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_q    <= 24'd0;
      div_cnt_q    <= 20'd0;
      fall_x_q     <= 10'd0;
      fall_y_q     <= 10'd0;
      fall_color_q <= COLOR_EMPTY;
      fall_valid_q <= 1'b0;
      score_q      <= 5'd0;
      misses_q     <= 2'd0;
      win_q        <= 1'b0;
    end else begin
      gap_cnt_q    <= gap_cnt_d;
      div_cnt_q    <= div_cnt_d;
      fall_x_q     <= fall_x_d;
      fall_y_q     <= fall_y_d;
      fall_color_q <= fall_color_d;
      fall_valid_q <= fall_valid_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      win_q        <= win_d;
    end
  end

  assign fall_x     = fall_x_q;
  assign fall_y     = fall_y_q;
  assign fall_color = fall_color_q;
  assign fall_valid = fall_valid_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign win        = win_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// tb/tb_drop_scheduler.sv - self-checking bench for drop_scheduler against a behavioural game model
module tb_drop_scheduler;

  localparam int P_FALL_DIV   = 4;
  localparam int P_SPAWN_GAP  = 8;
  localparam int P_FLOOR_Y    = 20;
  localparam int P_X_MIN      = 20;
  localparam int P_MAX_HEIGHT = 4;
  localparam int P_MAX_MISSES = 3;
  localparam int P_SEED       = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       collision = 1'b0;
  logic [9:0] fall_x, fall_y;
  logic [1:0] fall_color;
  logic       fall_valid;
  logic [4:0] score;
  logic [1:0] misses;
  logic       game_over, win;

  int vectors = 0;
  int miscompares = 0;

  drop_scheduler #(
    .FALL_DIV   (20'd4),
    .SPAWN_GAP  (24'd8),
    .FLOOR_Y    (10'd20),
    .X_MIN      (10'd20),
    .MAX_HEIGHT (5'd4),
    .MAX_MISSES (2'd3),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .collision  (collision),
    .fall_x     (fall_x),
    .fall_y     (fall_y),
    .fall_color (fall_color),
    .fall_valid (fall_valid),
    .score      (score),
    .misses     (misses),
    .game_over  (game_over),
    .win        (win)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 waiting to spawn, 2 block falling, 3 game over.
  // A falling block's y is simply its unpaused age divided by FALL_DIV.
  int m_mode, m_ticks, m_x, m_y, m_color, m_valid, m_score, m_misses, m_win, m_lfsr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_ticks = 0; m_x = 0; m_y = 0; m_color = 0; m_valid = 0;
      m_score = 0; m_misses = 0; m_win = 0; m_lfsr = P_SEED;
    end else begin
      case (m_mode)
        0, 3: if (start && !pause) begin
          m_mode = 1; m_ticks = 0; m_score = 0; m_misses = 0; m_win = 0;
        end
        1: if (!pause) begin
          m_ticks++;
          if (m_ticks == P_SPAWN_GAP) begin
            m_mode = 2; m_ticks = 0; m_valid = 1; m_y = 0;
            m_x = P_X_MIN + (m_lfsr % 512);
            m_color = (m_lfsr / 512) % 4;
            if (m_color == 0) m_color = 1;
          end
        end
        2: begin
          if (collision) begin
            if (m_score < P_MAX_HEIGHT) m_score++;
            m_valid = 0; m_y = 0; m_color = 0; m_ticks = 0;
            if (m_score == P_MAX_HEIGHT) begin m_mode = 3; m_win = 1; end
            else m_mode = 1;
          end else if (!pause) begin
            if (m_y >= P_FLOOR_Y) begin
              if (m_misses < P_MAX_MISSES) m_misses++;
              m_valid = 0; m_y = 0; m_color = 0; m_ticks = 0;
              m_mode = (m_misses == P_MAX_MISSES) ? 3 : 1;
            end else begin
              m_ticks++;
              m_y = m_ticks / P_FALL_DIV;
            end
          end
        end
        default: m_mode = 0;
      endcase
      if (!pause) begin
        int fb;
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (fall_x !== 10'(m_x) || fall_y !== 10'(m_y) || fall_color !== 2'(m_color) ||
          fall_valid !== 1'(m_valid) || score !== 5'(m_score) || misses !== 2'(m_misses) ||
          game_over !== (m_mode == 3) || win !== 1'(m_win)) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t: got x=%0d y=%0d c=%0d v=%0d s=%0d m=%0d go=%0d w=%0d expected x=%0d y=%0d c=%0d v=%0d s=%0d m=%0d go=%0d w=%0d",
                 $time, fall_x, fall_y, fall_color, fall_valid, score, misses, game_over, win,
                 m_x, m_y, m_color, m_valid, m_score, m_misses, (m_mode == 3), m_win);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!fall_valid && n < 100) begin tick(1); n++; end
    chk("wait_spawn", fall_valid, 1);
  endtask

  task automatic wait_retire();
    int n = 0;
    while (fall_valid && n < 300) begin tick(1); n++; end
    chk("wait_retire", fall_valid, 0);
  endtask

  task automatic land(input int expect_score);
    wait_valid();
    tick(2);
    collision = 1'b1; tick(1); collision = 1'b0;
    chk("land_score", score, expect_score);
    chk("land_valid", fall_valid, 0);
    chk("land_y", fall_y, 0);
  endtask

  initial begin
    int y0, s0, n;
    tick(3);
    rst = 1'b0;
    tick(50);
    chk("idle_valid", fall_valid, 0);
    chk("idle_y", fall_y, 0);
    chk("idle_score", score, 0);
    chk("idle_over", game_over, 0);

    // Spawn and fall
    pulse_start();
    tick(7);
    chk("pre_spawn_valid", fall_valid, 0);
    tick(1);
    chk("spawn_valid", fall_valid, 1);
    chk("spawn_color_range", int'(fall_color >= 1 && fall_color <= 3), 1);
    chk("spawn_x_range", int'(fall_x >= 20 && fall_x <= 531), 1);
    tick(3);
    chk("y_before_step", fall_y, 0);
    tick(1); chk("y_step1", fall_y, 1);
    tick(4); chk("y_step2", fall_y, 2);
    tick(4); chk("y_step3", fall_y, 3);

    // Landing and win
    collision = 1'b1; tick(1); collision = 1'b0;
    chk("land1_score", score, 1);
    chk("land1_valid", fall_valid, 0);
    chk("land1_y", fall_y, 0);
    for (int i = 2; i <= 4; i++) land(i);
    chk("win_over", game_over, 1);
    chk("win_flag", win, 1);

    // Misses
    pulse_start();
    chk("restart_score", score, 0);
    chk("restart_over", game_over, 0);
    for (int i = 1; i <= 3; i++) begin
      wait_valid();
      wait_retire();
      chk("miss_count", misses, i);
    end
    chk("lose_over", game_over, 1);
    chk("lose_win", win, 0);
    pulse_start();
    chk("clear_misses", misses, 0);
    chk("clear_score", score, 0);

    // Pause
    wait_valid();
    tick(6);
    pause = 1'b1;
    tick(1);
    y0 = fall_y;
    tick(15);
    start = 1'b1; tick(2); start = 1'b0;
    tick(23);
    chk("pause_y_held", fall_y, y0);
    chk("pause_valid", fall_valid, 1);
    collision = 1'b1; tick(1); collision = 1'b0;
    chk("pause_hit_score", score, 1);
    chk("pause_hit_valid", fall_valid, 0);
    tick(3);
    pause = 1'b0;

    // Collision coinciding with the floor
    wait_valid();
    s0 = score;
    n = 0;
    while (fall_y != 10'd20 && n < 200) begin tick(1); n++; end
    chk("reach_floor", fall_y, 20);
    collision = 1'b1; tick(1); collision = 1'b0;
    chk("floor_hit_score", score, s0 + 1);
    chk("floor_hit_misses", misses, 0);

    // Asynchronous reset mid-fall
    wait_valid();
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", fall_valid, 0);
    chk("arst_x", fall_x, 0);
    chk("arst_score", score, 0);
    chk("arst_color", fall_color, 0);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("post_rst_over", game_over, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drop_scheduler.md
# drop_scheduler

Sequences falling blocks for the stacking game and drives the `fall_x`/`fall_y`/`fall_color` inputs of the `stack` datapath.
- Runs the game state machine: idle, spawn gap, fall, game over.
- Spawns one block at a time at a pseudo-random x position with a pseudo-random nonzero color, and steps it down the screen.
- Retires the block when `stack` reports `collision` or when it reaches the floor.
- Tracks score (stack height) and misses, and declares game over on a win or on too many misses.

## Interface
- `FALL_DIV`, 20'd200000: clk cycles per 1-pixel fall step.
- `SPAWN_GAP`, 24'd5000000: clk cycles between retiring one block and spawning the next.
- `FLOOR_Y`, 10'd470: a block whose y reaches this value is a miss.
- `X_MIN`, 10'd20: minimum spawn x.
- `MAX_HEIGHT`, 5'd16: score at which the player wins.
- `MAX_MISSES`, 2'd3: miss count at which the player loses.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: level; sampled in IDLE and OVER.
- `pause` in 1: level; freezes all counters and the LFSR while high.
- `collision` in 1: from `stack`, registered; a 1 in any cycle means the current block landed.
- `fall_x` out 10: block x, registered.
- `fall_y` out 10: block y, registered; 0 when no block is live.
- `fall_color` out 2: block color 1..3; 0 when no block is live.
- `fall_valid` out 1: a block is live.
- `score` out 5: blocks landed this game.
- `misses` out 2: blocks missed this game.
- `game_over` out 1: high in OVER.
- `win` out 1: high in OVER when the end was by score; held until the next start.

## Operation
**States:** IDLE, GAP, FALL, OVER. Reset enters IDLE.

- **IDLE:** `start`=1 clears `score` and `misses`, loads `gap_cnt`=0, and goes to GAP.
- **GAP:** `gap_cnt` increments each unpaused cycle. When it reaches SPAWN_GAP-1 the block spawns and the state goes to FALL:
  - `fall_x` = X_MIN + `lfsr[8:0]`, in 10-bit arithmetic, giving X_MIN..X_MIN+511.
  - `fall_color` = `lfsr[10:9]`, with 2'b00 replaced by 2'b01.
  - `fall_y` = 0, `fall_valid` = 1, `div_cnt` = 0.
- **FALL:** `div_cnt` increments each unpaused cycle. When it reaches FALL_DIV-1 it wraps to 0 and `fall_y` increments by 1.
  - **Collision:** `collision`=1 has priority over every other FALL event. `score` increments, the block is retired, and:
    - if the new score == MAX_HEIGHT, go to OVER with `win`=1;
    - otherwise go to GAP.
  - **Miss:** otherwise, if `fall_y` >= FLOOR_Y, `misses` increments, the block is retired, and:
    - if the new misses == MAX_MISSES, go to OVER with `win`=0;
    - otherwise go to GAP.
  - **Retire:** `fall_valid`=0, `fall_y`=0, `fall_color`=0, `gap_cnt`=0. `fall_x` holds its value.
- **OVER:** `game_over`=1. `start`=1 goes to GAP, clears `score`, `misses` and `win`, and loads `gap_cnt`=0.

**LFSR:** 16-bit Fibonacci, taps 16, 14, 13, 11. It advances every unpaused cycle in every state, so spawn positions depend on player timing.

**Pause:**
- `pause`=1 freezes `gap_cnt`, `div_cnt`, `fall_y`, the LFSR and the state.
- `collision` is still honored while paused, with the same behavior as in FALL.
- `start` is ignored while paused.

**Other rules:**
- `start` is ignored in GAP and FALL.
- `score` saturates at MAX_HEIGHT; `misses` saturates at MAX_MISSES.
- `collision` outside FALL is ignored.

## Timing
- **Reset values:** `fall_x`=0, `fall_y`=0, `fall_color`=0, `fall_valid`=0, `score`=0, `misses`=0, `game_over`=0, `win`=0, LFSR=LFSR_SEED, state=IDLE.
- **Start to spawn:** the `start` edge is at cycle 0; `fall_valid` rises after SPAWN_GAP+1 edges.
- **Fall step:** `fall_y` steps every FALL_DIV unpaused cycles. The first step occurs FALL_DIV cycles after the spawn edge.
- **Retire latency:** `collision` sampled at edge t gives `fall_valid`=0 and `fall_y`=0 after edge t. `stack` therefore sees at most one overlapping y per landing.
- **Miss latency:** retirement occurs at the edge after `fall_y` first equals FLOOR_Y.
- **Mid-operation reset:** an asynchronous reset in any state immediately forces all reset values.

## Structure
- **Package `game_pkg`:**
  - state encoding: IDLE=2'd0, GAP=2'd1, FALL=2'd2, OVER=2'd3;
  - screen constants: SCREEN_W=640, SCREEN_H=480;
  - color width 2 and COLOR_EMPTY=2'd0.
- **Sub-module `lfsr16`:** inputs `clk`, `rst`, `en`; output `q[15:0]`; seed parameter.
- All remaining logic lives in `drop_scheduler`.

## Test plan
All scenarios use FALL_DIV=4, SPAWN_GAP=8, FLOOR_Y=20, MAX_MISSES=3, MAX_HEIGHT=4.
- **Reset and idle:** release reset and hold `start`=0 for 50 cycles. All outputs stay 0 and `game_over`=0.
- **Spawn and fall:** pulse `start`.
  - `fall_valid` rises 9 edges later with `fall_color` in 1..3 and `fall_x` in 20..531.
  - `fall_y` reads 1, 2, 3 at 4-cycle intervals.
- **Landing and win:** assert `collision` for 1 cycle during FALL.
  - Next cycle: `score`=1, `fall_valid`=0, `fall_y`=0.
  - Repeat 3 more times: `game_over`=1 and `win`=1.
- **Misses:** let 3 blocks reach y=20 with no collision. `misses` reads 1, 2, 3 and `game_over`=1 with `win`=0.
  - A further `start` returns `misses`=0, `score`=0.
- **Pause:** hold `pause` for 40 cycles mid-fall; `fall_y` is unchanged.
  - `collision` during the pause still retires the block with `score`+1.
  - `start` during the pause is ignored.
- **Simultaneous collision and floor:** raise `collision` in the cycle `fall_y`=20. `score` increments and `misses` is unchanged.
  - Also assert `rst` mid-FALL: all outputs read 0 immediately.
